// File: rtl/unidade_acesso_memoria_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
interface unidade_acesso_memoria_if #(
    parameter int LARGURA = 32
);
    // Handshake: mem_req holds high with mem_controle/mem_endereco/mem_valor stable
    // until a cycle with mem_aceite=1; the transfer happens on that edge.
    // For reads, mem_dado_valido qualifies mem_saida for one cycle, never earlier
    // than the cycle after the accept.
    logic               mem_req;
    logic               mem_controle;
    logic [LARGURA-1:0] mem_endereco;
    logic [LARGURA-1:0] mem_valor;
    logic               mem_aceite;
    logic               mem_dado_valido;
    logic [LARGURA-1:0] mem_saida;

    modport master (
        output mem_req, mem_controle, mem_endereco, mem_valor,
        input  mem_aceite, mem_dado_valido, mem_saida
    );

    modport slave (
        input  mem_req, mem_controle, mem_endereco, mem_valor,
        output mem_aceite, mem_dado_valido, mem_saida
    );
endinterface

// File: rtl/unidade_acesso_memoria.sv
// MEM-stage load/store initiator: issues one access at a time to the data memory,
// stalls the pipeline while it is outstanding and traps on misalignment or timeout.
module unidade_acesso_memoria #(
    parameter int LARGURA = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            op_valido,
    input  logic                            op_escrita,
    input  logic [LARGURA-1:0]              op_endereco,
    input  logic [LARGURA-1:0]              op_valor,
    input  logic [4:0]                      op_rd,
    output logic                            parar,
    unidade_acesso_memoria_if.master        mem,
    output logic                            wb_valido,
    output logic [LARGURA-1:0]              wb_dado,
    output logic [4:0]                      wb_rd,
    output logic                            erro,
    output logic [1:0]                      estado_dbg
);
    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_ACEITE = 2'd1,
        ESPERA_DADO   = 2'd2,
        FALHA         = 2'd3
    } estado_t;

    // The counter only has to reach TIMEOUT-1: the abort decision is taken
    // during the TIMEOUT-th waiting cycle.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    estado_t       estado;
    estado_t       estado_prox;
    logic [CW-1:0] contador;
    logic [4:0]    rd_r;
    logic          captura;
    logic          retorna;
    logic          esgotado;

    always_comb begin
        estado_prox = estado;
        captura     = 1'b0;
        retorna     = 1'b0;
        esgotado    = (contador == LIMITE);
        case (estado)
            OCIOSO: begin
                if (op_valido) begin
                    if (op_endereco[1:0] != 2'b00) begin
                        estado_prox = FALHA;
                    end else begin
                        captura     = 1'b1;
                        estado_prox = ESPERA_ACEITE;
                    end
                end
            end
            ESPERA_ACEITE: begin
                // A store accepted on the last allowed cycle still completes;
                // a load accepted then cannot receive data in time.
                if (mem.mem_aceite && mem.mem_controle) begin
                    estado_prox = OCIOSO;
                end else if (esgotado) begin
                    estado_prox = FALHA;
                end else if (mem.mem_aceite) begin
                    estado_prox = ESPERA_DADO;
                end
            end
            ESPERA_DADO: begin
                if (mem.mem_dado_valido) begin
                    retorna     = 1'b1;
                    estado_prox = OCIOSO;
                end else if (esgotado) begin
                    estado_prox = FALHA;
                end
            end
            FALHA: begin
                estado_prox = FALHA;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado           <= OCIOSO;
            contador         <= '0;
            rd_r             <= '0;
            mem.mem_controle <= 1'b0;
            mem.mem_endereco <= '0;
            mem.mem_valor    <= '0;
            wb_valido        <= 1'b0;
            wb_dado          <= '0;
            wb_rd            <= '0;
        end else begin
            estado    <= estado_prox;
            wb_valido <= retorna;
            if (captura) begin
                contador         <= '0;
                mem.mem_controle <= op_escrita;
                mem.mem_endereco <= {2'b00, op_endereco[LARGURA-1:2]};
                mem.mem_valor    <= op_valor;
                rd_r             <= op_rd;
            end else if (estado == ESPERA_ACEITE || estado == ESPERA_DADO) begin
                contador <= contador + 1'b1;
            end
            if (retorna) begin
                wb_dado <= mem.mem_saida;
                wb_rd   <= rd_r;
            end
        end
    end

    // Decoded from the state flops only, so no input reaches these combinationally.
    assign mem.mem_req = (estado == ESPERA_ACEITE);
    assign parar       = (estado != OCIOSO);
    assign erro        = (estado == FALHA);
    assign estado_dbg  = estado;
endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Directed bench for unidade_acesso_memoria: transaction-level model, per-cycle compare,
// load-result scoreboard and hand-computed latency/count checks.
module tb_unidade_acesso_memoria;
    localparam int LARGURA = 32;
    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic               op_valido;
    logic               op_escrita;
    logic [LARGURA-1:0] op_endereco;
    logic [LARGURA-1:0] op_valor;
    logic [4:0]         op_rd;
    logic               parar;
    logic               wb_valido;
    logic [LARGURA-1:0] wb_dado;
    logic [4:0]         wb_rd;
    logic               erro;
    logic [1:0]         estado_dbg;

    unidade_acesso_memoria_if #(.LARGURA(LARGURA)) mem ();

    unidade_acesso_memoria #(.LARGURA(LARGURA), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_valido   (op_valido),
        .op_escrita  (op_escrita),
        .op_endereco (op_endereco),
        .op_valor    (op_valor),
        .op_rd       (op_rd),
        .parar       (parar),
        .mem         (mem.master),
        .wb_valido   (wb_valido),
        .wb_dado     (wb_dado),
        .wb_rd       (wb_rd),
        .erro        (erro),
        .estado_dbg  (estado_dbg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    int               lat_aceite = 0;
    int               lat_dado   = 1;
    bit               sem_dado   = 1'b0;
    logic [31:0]      dado_resp  = '0;
    int               req_ciclos = 0;
    int               dado_cd    = 0;

    always @(posedge clock) begin
        #1;
        mem.mem_aceite      = 1'b0;
        mem.mem_dado_valido = 1'b0;
        mem.mem_saida       = $urandom();
        if (!reset_n) begin
            req_ciclos = 0;
            dado_cd    = 0;
        end else begin
            if (dado_cd > 0) begin
                dado_cd--;
                if (dado_cd == 0 && !sem_dado) begin
                    mem.mem_dado_valido = 1'b1;
                    mem.mem_saida       = dado_resp;
                end
            end
            if (mem.mem_req === 1'b1) begin
                if (req_ciclos == lat_aceite) begin
                    mem.mem_aceite = 1'b1;
                    req_ciclos     = 0;
                    if (mem.mem_controle === 1'b0) dado_cd = lat_dado;
                end else begin
                    req_ciclos++;
                end
            end else begin
                req_ciclos = 0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    bit          m_ocupado = 0, m_aceito = 0, m_escrita = 0, m_falha = 0, m_wb = 0;
    int          m_espera  = 0;
    logic [31:0] m_end = '0, m_valor = '0, m_wb_dado = '0;
    logic [4:0]  m_rd = '0, m_wb_rd = '0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_ocupado = 0; m_aceito = 0; m_escrita = 0; m_falha = 0; m_wb = 0;
            m_espera = 0; m_end = '0; m_valor = '0; m_rd = '0; m_wb_dado = '0; m_wb_rd = '0;
        end else begin
            m_wb = 0;
            if (m_falha) begin
                m_falha = 1;
            end else if (!m_ocupado) begin
                if (op_valido) begin
                    if (op_endereco % 4 != 0) begin
                        m_falha = 1;
                    end else begin
                        m_ocupado = 1; m_aceito = 0; m_espera = 0;
                        m_escrita = op_escrita; m_end = op_endereco / 4;
                        m_valor = op_valor; m_rd = op_rd;
                    end
                end
            end else begin
                m_espera++;
                if (!m_aceito) begin
                    if (mem.mem_aceite) begin
                        if (m_escrita) m_ocupado = 0;
                        else           m_aceito  = 1;
                    end
                end else if (mem.mem_dado_valido) begin
                    m_ocupado = 0; m_wb = 1; m_wb_dado = mem.mem_saida; m_wb_rd = m_rd;
                end
                if (m_ocupado && m_espera == TIMEOUT) begin
                    m_falha = 1; m_ocupado = 0;
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    logic [36:0] exp_q[$];
    int          req_cycs[$];
    logic [31:0] req_end[$];
    int          wb_cycs[$];
    int          n_parar  = 0;
    int          erro_cyc = -1;
    logic [31:0] last_wb_dado = '0;
    logic [4:0]  last_wb_rd   = '0;

    always @(negedge clock) begin
        check("parar", parar, m_ocupado || m_falha);
        check("erro", erro, m_falha);
        check("mem_req", mem.mem_req, m_ocupado && !m_aceito);
        check("wb_valido", wb_valido, m_wb);
        if (m_ocupado && !m_aceito) begin
            check("mem_controle", mem.mem_controle, m_escrita);
            check("mem_endereco", mem.mem_endereco, m_end);
            check("mem_valor", mem.mem_valor, m_valor);
        end
        if (m_wb) begin
            check("wb_dado", wb_dado, m_wb_dado);
            check("wb_rd", wb_rd, m_wb_rd);
        end
        if (mem.mem_req === 1'b1) begin
            req_cycs.push_back(cyc);
            req_end.push_back(mem.mem_endereco);
        end
        if (parar === 1'b1) n_parar++;
        if (erro === 1'b1 && erro_cyc < 0) erro_cyc = cyc;
        if (wb_valido === 1'b1) begin
            wb_cycs.push_back(cyc);
            last_wb_dado = wb_dado;
            last_wb_rd   = wb_rd;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_scoreboard: got %0h expected none", {wb_rd, wb_dado});
            end else begin
                check("wb_scoreboard", {wb_rd, wb_dado}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic passo();
        @(posedge clock);
        #2;
    endtask

    task automatic limpa_mon();
        req_cycs.delete(); req_end.delete(); wb_cycs.delete();
        n_parar = 0; erro_cyc = -1;
    endtask

    task automatic enviar(input bit escrita, input logic [31:0] endr, input logic [31:0] valor,
                          input logic [4:0] rd);
        op_valido = 1'b1; op_escrita = escrita; op_endereco = endr; op_valor = valor; op_rd = rd;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (parar === 1'b0) begin
                passo();
                op_valido = 1'b0; op_escrita = 1'b0; op_endereco = '0; op_valor = '0; op_rd = '0;
                return;
            end
        end
        op_valido = 1'b0;
        total++; bad++;
        $display("FAIL enviar: got parar stuck expected idle within 60 cycles");
    endtask

    task automatic esperar_ocioso(input int limite);
        bit ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (parar === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL esperar_ocioso: got busy expected idle within %0d cycles", limite);
        end
        passo();
    endtask

    task automatic checa_reset(input string tag);
        check({tag, "_mem_req"}, mem.mem_req, 1'b0);
        check({tag, "_parar"}, parar, 1'b0);
        check({tag, "_erro"}, erro, 1'b0);
        check({tag, "_wb_valido"}, wb_valido, 1'b0);
        check({tag, "_mem_controle"}, mem.mem_controle, 1'b0);
        check({tag, "_mem_endereco"}, mem.mem_endereco, 32'h0);
        check({tag, "_mem_valor"}, mem.mem_valor, 32'h0);
        check({tag, "_wb_dado"}, wb_dado, 32'h0);
        check({tag, "_wb_rd"}, wb_rd, 5'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        op_valido = 1'b0; op_escrita = 1'b0; op_endereco = '0; op_valor = '0; op_rd = '0;
        repeat (3) passo();
        checa_reset("rst");
        reset_n = 1'b1;
        passo();

        // store, zero-wait memory
        limpa_mon(); lat_aceite = 0; lat_dado = 1;
        enviar(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
        esperar_ocioso(20);
        repeat (2) passo();
        check("st_req_cycles", req_cycs.size(), 1);
        if (req_end.size() > 0) check("st_endereco", req_end[0], 32'h4);
        check("st_parar_cycles", n_parar, 1);
        check("st_no_wb", wb_cycs.size(), 0);

        // load, accept after 3 cycles, data 2 cycles after accept
        limpa_mon(); lat_aceite = 3; lat_dado = 2; dado_resp = 32'h1234_5678;
        exp_q.push_back({5'd5, 32'h1234_5678});
        enviar(1'b0, 32'h0000_0008, 32'h0, 5'd5);
        esperar_ocioso(30);
        repeat (2) passo();
        check("ld_req_cycles", req_cycs.size(), 4);
        check("ld_parar_cycles", n_parar, 6);
        check("ld_wb_count", wb_cycs.size(), 1);
        check("ld_wb_dado", last_wb_dado, 32'h1234_5678);
        check("ld_wb_rd", last_wb_rd, 5'd5);

        // back-to-back load then store, zero-wait memory
        limpa_mon(); lat_aceite = 0; lat_dado = 1; dado_resp = 32'hCAFE_0001;
        exp_q.push_back({5'd9, 32'hCAFE_0001});
        enviar(1'b0, 32'h0000_0100, 32'h0, 5'd9);
        enviar(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 5'd0);
        esperar_ocioso(30);
        repeat (2) passo();
        check("b2b_req_cycles", req_cycs.size(), 2);
        check("b2b_parar_cycles", n_parar, 3);
        check("b2b_wb_count", wb_cycs.size(), 1);
        if (req_cycs.size() == 2) begin
            check("b2b_req_spacing", req_cycs[1] - req_cycs[0], 3);
            check("b2b_end0", req_end[0], 32'h40);
            check("b2b_end1", req_end[1], 32'h41);
        end
        if (req_cycs.size() > 0 && wb_cycs.size() > 0)
            check("b2b_load_latency", wb_cycs[0] - req_cycs[0], 2);

        // reset while waiting for accept
        limpa_mon(); lat_aceite = 10;
        enviar(1'b0, 32'h0000_0020, 32'h0, 5'd1);
        passo(); passo();
        reset_n = 1'b0;
        passo();
        checa_reset("midrst");
        reset_n = 1'b1; lat_aceite = 0;
        repeat (5) passo();
        check("midrst_req_cycles", req_cycs.size(), 3);

        // timeout: accepted load whose data never comes
        limpa_mon(); lat_aceite = 0; sem_dado = 1'b1;
        enviar(1'b0, 32'h0000_0030, 32'h0, 5'd2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (erro === 1'b1) break;
        end
        passo();
        check("to_erro", erro, 1'b1);
        check("to_req_cycles", req_cycs.size(), 1);
        if (req_cycs.size() > 0) check("to_latency", erro_cyc - req_cycs[0], 15);
        reset_n = 1'b0;
        passo(); passo();
        reset_n = 1'b1; sem_dado = 1'b0;
        passo();

        // misaligned load traps and ignores later ops
        limpa_mon();
        enviar(1'b0, 32'h0000_0006, 32'h0, 5'd3);
        check("mis_erro", erro, 1'b1);
        check("mis_parar", parar, 1'b1);
        op_valido = 1'b1; op_endereco = 32'h0000_0040;
        repeat (4) passo();
        op_valido = 1'b0; op_endereco = '0;
        repeat (2) passo();
        check("mis_erro_held", erro, 1'b1);
        check("mis_no_req", req_cycs.size(), 0);
        reset_n = 1'b0;
        passo();
        check("mis_rst_erro", erro, 1'b0);
        check("mis_rst_parar", parar, 1'b0);
        reset_n = 1'b1;
        repeat (2) passo();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
